// File: rtl/pipe_regfile_sb_if.sv
// Decode-stage register file bus: operand reads, writeback and destination reservation.
// The master side (pipeline) drives addresses and strobes; the slave side (register file) returns data and status.
interface pipe_regfile_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             iss_ready;
    logic             flush;

    modport master (
        output rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr, flush,
        input  rd_data, rd_busy, iss_ready
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr, flush,
        output rd_data, rd_busy, iss_ready
    );
endinterface

// File: rtl/pipe_regfile_sb.sv
// Register file with NR combinational read ports, one write port and a per-register pending-write scoreboard.
// Optional macro RF_BYPASS_EN enables same-cycle write-through forwarding of data and busy release.
module pipe_regfile_sb #(
    parameter int            DW      = 32,
    parameter int            AW      = 5,
    parameter int            NR      = 2,
    parameter int            CW      = 2,
    parameter int            GP_IDX  = 28,
    parameter logic [DW-1:0] GP_INIT = DW'(32'h0000_1800),
    parameter int            SP_IDX  = 29,
    parameter logic [DW-1:0] SP_INIT = DW'(32'h0000_0ffc)
) (
    input  logic             clk,
    input  logic             reset,
    pipe_regfile_sb_if.slave bus
);
    localparam int            DEPTH   = 1 << AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [CW-1:0] cnt_q [DEPTH];
    logic [CW-1:0] cnt_d [DEPTH];
    logic [AW-1:0] rd_a  [NR];
    logic          wr_en;
    logic          acc;
    logic [NR*DW-1:0] rd_data_c;
    logic [NR-1:0]    rd_busy_c;

    function automatic logic [DW-1:0] reset_val(input int idx);
        if (idx == GP_IDX)      return GP_INIT;
        else if (idx == SP_IDX) return SP_INIT;
        else                    return '0;
    endfunction

    for (genvar g = 0; g < NR; g++) begin : g_ra
        assign rd_a[g] = bus.rd_addr[g*AW +: AW];
    end

    // Nothing is taken while reset is held, so forwarding also stays quiet then.
    assign wr_en         = bus.we && (bus.wr_addr != '0) && !reset;
    assign bus.iss_ready = (bus.iss_addr == '0) || (cnt_q[bus.iss_addr] != CNT_MAX);
    assign acc           = bus.iss_valid && bus.iss_ready && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_val(i);
        end else if (wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A same-register issue and writeback cancel; flush keeps only this cycle's issue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 0) begin
                cnt_d[i] = '0;
            end else if (bus.flush) begin
                cnt_d[i] = (acc && bus.iss_addr == AW'(i)) ? CW'(1) : '0;
            end else if (acc && bus.iss_addr == AW'(i)) begin
                if (!(wr_en && bus.wr_addr == AW'(i))) cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (wr_en && bus.wr_addr == AW'(i) && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NR; k++) begin
            if (rd_a[k] != '0) begin
                rd_data_c[k*DW +: DW] = mem_q[rd_a[k]];
                rd_busy_c[k]          = (cnt_q[rd_a[k]] != '0);
`ifdef RF_BYPASS_EN
                if (wr_en && bus.wr_addr == rd_a[k]) begin
                    rd_data_c[k*DW +: DW] = bus.wr_data;
                    if (cnt_q[rd_a[k]] == CW'(1) && !bus.flush &&
                        !(acc && bus.iss_addr == rd_a[k]))
                        rd_busy_c[k] = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed bench for pipe_regfile_sb: reset image, write/read, forwarding, scoreboard, flush and async reset.
module tb_pipe_regfile_sb;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    pipe_regfile_sb_if #(.DW(32), .AW(5), .NR(2)) bus ();

    pipe_regfile_sb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] reset_img(input int a);
        if (a == 28)      return 32'h0000_1800;
        else if (a == 29) return 32'h0000_0ffc;
        else              return 32'h0;
    endfunction

    task automatic idle();
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        logic [31:0] e0, e1;
        reset = 1'b1;
        idle();
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            bus.iss_addr = 5'(a);
            #1;
            e0 = reset_img(a);
            e1 = reset_img(31 - a);
            n_vec++;
            if (bus.rd_data[31:0] !== e0) begin
                n_bad++; $display("FAIL reset_p0 r%0d: got %h want %h", a, bus.rd_data[31:0], e0);
            end
            n_vec++;
            if (bus.rd_data[63:32] !== e1) begin
                n_bad++; $display("FAIL reset_p1 r%0d: got %h want %h", 31 - a, bus.rd_data[63:32], e1);
            end
            n_vec++;
            if (bus.rd_busy !== 2'b00) begin
                n_bad++; $display("FAIL reset_busy r%0d: got %b want 00", a, bus.rd_busy);
            end
            n_vec++;
            if (bus.iss_ready !== 1'b1) begin
                n_bad++; $display("FAIL reset_ready r%0d: got %b want 1", a, bus.iss_ready);
            end
        end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_write();
        set_rd(5'd0, 5'd5);
        bus.we = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_data[63:32] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL write_r5: got %h want deadbeef", bus.rd_data[63:32]);
        end
        set_rd(5'd0, 5'd0);
        bus.we = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h0000_1234;
        #1;
        n_vec++;
        if (bus.rd_data[31:0] !== 32'h0) begin
            n_bad++; $display("FAIL write_r0_same: got %h want 0", bus.rd_data[31:0]);
        end
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_data !== 64'h0) begin
            n_bad++; $display("FAIL write_r0: got %h want 0", bus.rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
`ifdef RF_BYPASS_EN
        exp = 32'hA5A5_A5A5;
`else
        exp = 32'h0;
`endif
        set_rd(5'd7, 5'd7);
        bus.we = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5A5_A5A5;
        #1;
        n_vec++;
        if (bus.rd_data[31:0] !== exp) begin
            n_bad++; $display("FAIL bypass_same: got %h want %h", bus.rd_data[31:0], exp);
        end
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_data[31:0] !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL bypass_next: got %h want a5a5a5a5", bus.rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        logic [1:0] exp_b;
        set_rd(5'd9, 5'd9);
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus.iss_ready !== 1'b1) begin
                n_bad++; $display("FAIL sb_fill_ready cnt%0d: got %b want 1", i, bus.iss_ready);
            end
            tick();
        end
        #1;
        n_vec++;
        if (bus.iss_ready !== 1'b0) begin
            n_bad++; $display("FAIL sb_sat_ready: got %b want 0", bus.iss_ready);
        end
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL sb_sat_busy: got %b want 11", bus.rd_busy);
        end
        // Saturated issue alongside a writeback must not be taken.
        bus.we = 1'b1; bus.wr_addr = 5'd9;
        tick();
        bus.we = 1'b0; bus.iss_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL sb_wb1_ready: got %b want 1", bus.iss_ready);
        end
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL sb_wb1_busy: got %b want 11", bus.rd_busy);
        end
        bus.we = 1'b1; bus.wr_addr = 5'd9;
        tick();
`ifdef RF_BYPASS_EN
        exp_b = 2'b00;
`else
        exp_b = 2'b11;
`endif
        #1;
        n_vec++;
        if (bus.rd_busy !== exp_b) begin
            n_bad++; $display("FAIL sb_last_wb_busy: got %b want %b", bus.rd_busy, exp_b);
        end
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL sb_drained_busy: got %b want 00", bus.rd_busy);
        end
        bus.we = 1'b1; bus.wr_addr = 5'd9;
        tick();
        bus.we = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL sb_no_underflow: got %b want 11", bus.rd_busy);
        end
    endtask

    task automatic test_back_to_back();
        set_rd(5'd9, 5'd9);
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        bus.we = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000_0055;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL b2b_same_busy: got %b want 11", bus.rd_busy);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL b2b_busy: got %b want 11", bus.rd_busy);
        end
        n_vec++;
        if (bus.rd_data[31:0] !== 32'h0000_0055) begin
            n_bad++; $display("FAIL b2b_data: got %h want 00000055", bus.rd_data[31:0]);
        end
        bus.we = 1'b1; bus.wr_addr = 5'd9;
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL b2b_release: got %b want 00", bus.rd_busy);
        end
    endtask

    task automatic test_flush();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
        tick();
        tick();
        bus.iss_addr = 5'd4;
        tick();
        bus.iss_valid = 1'b0;
        set_rd(5'd3, 5'd4);
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b11) begin
            n_bad++; $display("FAIL flush_pre_busy: got %b want 11", bus.rd_busy);
        end
        bus.flush = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
        bus.we = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h0000_0033;
        #1;
        n_vec++;
        if (bus.iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_ready: got %b want 1", bus.iss_ready);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b10) begin
            n_bad++; $display("FAIL flush_busy: got %b want 10", bus.rd_busy);
        end
        n_vec++;
        if (bus.rd_data[31:0] !== 32'h0000_0033) begin
            n_bad++; $display("FAIL flush_data: got %h want 00000033", bus.rd_data[31:0]);
        end
        bus.we = 1'b1; bus.wr_addr = 5'd4;
        tick();
        bus.we = 1'b0;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL flush_r4_count: got %b want 00", bus.rd_busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd10;
        bus.we = 1'b1; bus.wr_addr = 5'd28; bus.wr_data = 32'h0000_0077;
        tick();
        idle();
        set_rd(5'd10, 5'd28);
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b01) begin
            n_bad++; $display("FAIL rmid_pre_busy: got %b want 01", bus.rd_busy);
        end
        n_vec++;
        if (bus.rd_data[63:32] !== 32'h0000_0077) begin
            n_bad++; $display("FAIL rmid_pre_data: got %h want 00000077", bus.rd_data[63:32]);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL rmid_busy: got %b want 00", bus.rd_busy);
        end
        n_vec++;
        if (bus.rd_data[63:32] !== 32'h0000_1800) begin
            n_bad++; $display("FAIL rmid_gp: got %h want 00001800", bus.rd_data[63:32]);
        end
        set_rd(5'd5, 5'd29);
        bus.we = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hFFFF_FFFF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
        #1;
        n_vec++;
        if (bus.rd_data !== {32'h0000_0ffc, 32'h0}) begin
            n_bad++; $display("FAIL rmid_data: got %h want 00000ffc00000000", bus.rd_data);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (bus.rd_data[31:0] !== 32'h0 || bus.rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL rmid_no_take: got %h/%b want 00000000/00", bus.rd_data[31:0], bus.rd_busy);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.rd_addr = '0;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_regfile_sb.md
# pipe_regfile_sb

Parametrised pipeline register file with N read ports, one write port, optional write-through forwarding and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined CPU: decode reads operands and busy status here, issue reserves the destination register, and writeback releases it. Register 0 is hardwired to zero and never pending. The global pointer and stack pointer reset to configurable values.

## Interface
Parameters:
- DW, 32, data width
- AW, 5, address width; depth = 2^AW, entries 1..2^AW-1 stored
- NR, 2, number of read ports
- CW, 2, scoreboard counter width; max outstanding writes per register = 2^CW-1
- GP_IDX, 28, index of the global-pointer register
- GP_INIT, 32'h00001800, reset value of GP_IDX
- SP_IDX, 29, index of the stack-pointer register
- SP_INIT, 32'h00000ffc, reset value of SP_IDX

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NR*AW  read addresses; port k occupies [k*AW +: AW]
- rd_data  out  NR*DW  read data; port k occupies [k*DW +: DW]
- rd_busy  out  NR  port k's register has an outstanding write
- we  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  DW  writeback data
- iss_valid  in  1  issue request reserving iss_addr
- iss_addr  in  AW  destination register being reserved
- iss_ready  out  1  reservation can be accepted this cycle
- flush  in  1  synchronous clear of all reservations

## Operation
- Storage: entries 1..2^AW-1. Address 0 always reads 0, is never busy, and ignores writes and issues.
- Read: combinational. rd_data[k] = 0 if rd_addr[k]==0, else stored value, with forwarding applied per Configuration.
- Write: at a rising edge, if we && wr_addr!=0, store wr_data. This happens regardless of the scoreboard count.
- Scoreboard: one CW-bit counter per entry.
  - Issue acceptance: acc = iss_valid && iss_ready.
  - iss_ready = (iss_addr==0) || cnt[iss_addr] != 2^CW-1. It is combinational from counters only and does not depend on the same-cycle writeback.
  - Accepted issue to a nonzero address increments that counter.
  - Writeback with we && wr_addr!=0 decrements that counter if it is nonzero. A writeback to a register whose counter is 0 leaves the counter at 0.
  - Accepted issue and writeback to the same register in the same cycle leave that counter unchanged.
  - flush: all counters become 0 and same-cycle writeback decrements are discarded. A same-cycle accepted issue is still counted, giving 1. Data writes are unaffected by flush.
- rd_busy[k] = (rd_addr[k]!=0) && cnt[rd_addr[k]]!=0, adjusted per Configuration.

## Timing
- Reset: every entry is 0 except GP_IDX=GP_INIT and SP_IDX=SP_INIT, and all counters are 0. During reset, rd_data shows these values, rd_busy=0 and iss_ready=1.
- Reset asserted mid-operation clears counters and data immediately. No write or issue is taken while reset is high.
- Write latency: 1 cycle; the value is visible in storage from the next cycle.
- Scoreboard latency: 1 cycle; rd_busy and iss_ready reflect the updated counters from the next cycle.
- Saturation: when a counter is at 2^CW-1, iss_ready=0. Issue is then accepted only after that counter drops, even if a writeback to that register arrives in the same cycle.
- All read ports are independent. Two ports reading the same address return identical data and busy values.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding is enabled.
  - If we && wr_addr==rd_addr[k]!=0, rd_data[k]=wr_data in the same cycle.
  - rd_busy[k] is also deasserted in that cycle when cnt==1 and there is no accepted issue or flush to that address this cycle.
- RF_BYPASS_EN undefined: reads return stored values only, and rd_busy reflects registered counters only. The writing stage must then use a split-cycle register file or hold the read one extra cycle.

## Test plan
- Reset check: read all 32 addresses across both ports -> r28=0x1800, r29=0xffc, all others 0, rd_busy=0, iss_ready=1.
- Write then read: write 0xDEADBEEF to r5 with we=1, then read r5 on port 1 the next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Bypass: same-cycle write of 0xA5A5A5A5 to r7 while port 0 reads r7.
  - RF_BYPASS_EN defined -> rd_data=0xA5A5A5A5.
  - RF_BYPASS_EN undefined -> old value.
- Scoreboard: issue r9 three times (CW=2) -> cnt=3 and iss_ready=0 for r9. One writeback -> iss_ready=1 and rd_busy still 1. Two more writebacks -> rd_busy=0.
- Simultaneous issue and writeback to r9 with cnt=1 -> cnt stays 1 and rd_busy stays 1, and wr_data is stored.
- Flush: with r3 cnt=2 and r4 cnt=1, assert flush with a same-cycle issue to r4 -> r3 cnt=0, r4 cnt=1. Assert reset mid-sequence -> all counters 0 and data restored to reset values.
